// File: rtl/regfile_pkg.sv
// Shared register-file constants and the register index type.
package regfile_pkg;
  localparam int DATA_WIDTH  = 32;
  localparam int REG_NUM     = 32;
  localparam int REG_NUM_BIT = 5;

  typedef logic [REG_NUM_BIT-1:0] reg_idx_t;

  localparam reg_idx_t REG_X0 = 5'd0;
endpackage

// File: rtl/regfile_wb_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr, and the first
// valid requester found gets a one-hot grant.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  int  idx;
  logic found;

  // Walk the requesters in priority order starting at ptr.
  always_comb begin
    grant = {N{1'b0}};
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx        = (int'(ptr) + k) % N;
      grant[idx] = valid[idx] & ~found;
      found      = found | valid[idx];
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back arbiter and busy scoreboard for a 2R1W register file.
// Define RF_WB_TRACE_EN for a simulation-only trace of writes and stalls.
module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH  = regfile_pkg::DATA_WIDTH,
  parameter int REG_NUM     = regfile_pkg::REG_NUM,
  parameter int REG_NUM_BIT = regfile_pkg::REG_NUM_BIT,
  parameter int NREQ        = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*REG_NUM_BIT-1:0] req_waddr,
  input  logic [NREQ*DATA_WIDTH-1:0]  req_wdata,
  output logic                        rf_wen,
  output logic [REG_NUM_BIT-1:0]      rf_waddr,
  output logic [DATA_WIDTH-1:0]       rf_wdata,
  input  logic                        iss_valid,
  input  logic [REG_NUM_BIT-1:0]      iss_rd,
  input  logic [REG_NUM_BIT-1:0]      chk_a,
  input  logic [REG_NUM_BIT-1:0]      chk_b,
  output logic                        stall,
  output logic [REG_NUM-1:0]          busy
);

  localparam int PTR_W = $clog2(NREQ);

  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic                   rf_wen_q, rf_wen_d;
  logic [REG_NUM_BIT-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0]  rf_wdata_q, rf_wdata_d;
  logic [REG_NUM-1:0]     busy_q, busy_d;

  logic [NREQ-1:0]        grant;
  logic                   transfer;
  logic [PTR_W-1:0]       win_idx;
  logic [REG_NUM_BIT-1:0] win_addr;
  logic [DATA_WIDTH-1:0]  win_data;
  logic                   issue_ok;

  rr_arbiter #(.N(NREQ), .PW(PTR_W)) u_arb (
    .valid (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  assign req_ready = grant;

  // Mux the single winner's request; grant is one-hot so OR-reduction suffices.
  always_comb begin
    transfer = 1'b0;
    win_idx  = {PTR_W{1'b0}};
    win_addr = {REG_NUM_BIT{1'b0}};
    win_data = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      transfer = transfer | (grant[i] & req_valid[i]);
      win_idx  = win_idx  | (PTR_W'(i) & {PTR_W{grant[i] & req_valid[i]}});
      win_addr = win_addr | (req_waddr[i*REG_NUM_BIT +: REG_NUM_BIT] &
                             {REG_NUM_BIT{grant[i] & req_valid[i]}});
      win_data = win_data | (req_wdata[i*DATA_WIDTH +: DATA_WIDTH] &
                             {DATA_WIDTH{grant[i] & req_valid[i]}});
    end
  end

  // Next pointer and write-port register; x0 writes are consumed but never enabled.
  always_comb begin
    ptr_d      = transfer ? ((win_idx == PTR_W'(NREQ - 1)) ? {PTR_W{1'b0}}
                                                           : win_idx + PTR_W'(1))
                          : ptr_q;
    rf_wen_d   = transfer & (win_addr != REG_NUM_BIT'(REG_X0));
    rf_waddr_d = transfer ? win_addr : rf_waddr_q;
    rf_wdata_d = transfer ? win_data : rf_wdata_q;
  end

  assign stall    = iss_valid & (busy_q[chk_a] | busy_q[chk_b] | busy_q[iss_rd]);
  assign issue_ok = iss_valid & ~stall & (iss_rd != REG_NUM_BIT'(REG_X0));

  // Clear on retire, then set on issue so a same-index set wins.
  always_comb begin
    busy_d             = busy_q;
    busy_d[rf_waddr_q] = busy_q[rf_waddr_q] & ~rf_wen_q;
    busy_d[iss_rd]     = busy_d[iss_rd] | issue_ok;
    busy_d[0]          = 1'b0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= {PTR_W{1'b0}};
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= {REG_NUM_BIT{1'b0}};
      rf_wdata_q <= {DATA_WIDTH{1'b0}};
      busy_q     <= {REG_NUM{1'b0}};
    end else begin
      ptr_q      <= ptr_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = busy_q;

`ifdef RF_WB_TRACE_EN
  // Simulation trace of committed writes and stalled issue attempts.
  always_ff @(posedge clk) begin
    if (rf_wen_q) begin
      $display("RF WB x%0d <= %h", rf_waddr_q, rf_wdata_q);
    end
    if (stall) begin
      $display("RF STALL %0d/%0d/%0d", chk_a, chk_b, iss_rd);
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed plus randomized bench for regfile_wb_ctrl against a behavioural model.
module tb_regfile_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [9:0]  req_waddr;
  logic [63:0] req_wdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        iss_valid;
  logic [4:0]  iss_rd, chk_a, chk_b;
  logic        stall;
  logic [31:0] busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_p;
  logic [31:0] m_busy;
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [1:0]  m_grant;
  logic [1:0]  last_ready;
  logic        last_stall;
  logic        prev_rst;

  regfile_wb_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_waddr(req_waddr), .req_wdata(req_wdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .chk_a(chk_a), .chk_b(chk_b),
    .stall(stall), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational outputs, advance model, check registered outputs.
  task automatic cycle();
    logic [1:0] g;
    int         w;
    logic       st;
    logic [4:0] a;
    #1;
    g = 2'b00;
    w = -1;
    for (int k = 0; k < 2; k++) begin
      int i;
      i = (m_p + k) % 2;
      if (w < 0 && req_valid[i]) w = i;
    end
    if (w >= 0) g[w] = 1'b1;
    st = iss_valid && (m_busy[chk_a] || m_busy[chk_b] || m_busy[iss_rd]);
    chk("req_ready", {62'd0, req_ready}, {62'd0, g});
    chk("stall", {63'd0, stall}, {63'd0, st});
    last_ready = req_ready;
    last_stall = stall;
    m_grant    = g;
    if (rst) begin
      m_busy  = 32'd0;
      m_wen   = 1'b0;
      m_waddr = 5'd0;
      m_wdata = 32'd0;
      m_p     = 0;
    end else begin
      if (m_wen) m_busy[m_waddr] = 1'b0;
      if (iss_valid && !st && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
      m_busy[0] = 1'b0;
      if (w >= 0) begin
        a       = req_waddr[w*5 +: 5];
        m_wen   = (a != 5'd0);
        m_waddr = a;
        m_wdata = req_wdata[w*32 +: 32];
        m_p     = (w + 1) % 2;
      end else begin
        m_wen = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("rf_wen", {63'd0, rf_wen}, {63'd0, m_wen});
    chk("rf_waddr", {59'd0, rf_waddr}, {59'd0, m_waddr});
    chk("rf_wdata", {32'd0, rf_wdata}, {32'd0, m_wdata});
    chk("busy", {32'd0, busy}, {32'd0, m_busy});
  endtask

  initial begin
    m_p = 0; m_busy = 32'd0; m_wen = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
    m_grant = 2'b00;
    rst = 1'b1; req_valid = 2'b00; req_waddr = 10'd0; req_wdata = 64'd0;
    iss_valid = 1'b0; iss_rd = 5'd0; chk_a = 5'd0; chk_b = 5'd0;
    cycle();
    chk("reset rf_wen", {63'd0, rf_wen}, 64'd0);
    chk("reset busy", {32'd0, busy}, 64'd0);

    // 1: both requesters valid, grants alternate
    rst = 1'b0;
    req_valid = 2'b11;
    req_waddr = {5'd4, 5'd3};
    req_wdata = {32'hBBBB_0002, 32'hAAAA_0001};
    for (int n = 0; n < 4; n++) begin
      cycle();
      chk("t1 grant", {62'd0, last_ready}, (n % 2 == 0) ? 64'd1 : 64'd2);
      chk("t1 waddr", {59'd0, rf_waddr}, (n % 2 == 0) ? 64'd3 : 64'd4);
      chk("t1 wen", {63'd0, rf_wen}, 64'd1);
    end

    // 2: x0 write consumed and dropped
    req_valid = 2'b01;
    req_waddr = {5'd4, 5'd0};
    req_wdata = {32'hBBBB_0002, 32'hFFFF_FFFF};
    cycle();
    chk("t2 grant", {62'd0, last_ready}, 64'd1);
    chk("t2 wen", {63'd0, rf_wen}, 64'd0);
    chk("t2 busy", {32'd0, busy}, 64'd0);

    // 3: RAW stall on x5 released by write-back
    req_valid = 2'b00;
    iss_valid = 1'b1; iss_rd = 5'd5;
    cycle();
    chk("t3 busy5 set", {63'd0, busy[5]}, 64'd1);
    iss_rd = 5'd0; chk_a = 5'd5;
    cycle();
    chk("t3 stall", {63'd0, last_stall}, 64'd1);
    req_valid = 2'b10;
    req_waddr = {5'd5, 5'd0};
    req_wdata = {32'h0000_0055, 32'd0};
    cycle();
    chk("t3 grant1", {62'd0, last_ready}, 64'd2);
    chk("t3 wen x5", {58'd0, rf_wen, rf_waddr}, 64'h25);
    req_valid = 2'b00;
    cycle();
    chk("t3 busy5 clr", {63'd0, busy[5]}, 64'd0);
    cycle();
    chk("t3 stall drop", {63'd0, last_stall}, 64'd0);

    // 4: same-cycle clear and set of x7, set wins
    iss_valid = 1'b0; chk_a = 5'd0;
    req_valid = 2'b01;
    req_waddr = {5'd0, 5'd7};
    req_wdata = {32'd0, 32'h0000_0077};
    cycle();
    req_valid = 2'b00;
    iss_valid = 1'b1; iss_rd = 5'd7;
    cycle();
    chk("t4 busy7", {63'd0, busy[7]}, 64'd1);

    // 5: reset mid-operation returns pointer to 0
    iss_valid = 1'b0; iss_rd = 5'd0;
    req_valid = 2'b01;
    req_waddr = {5'd9, 5'd2};
    cycle();
    rst = 1'b1;
    req_valid = 2'b11;
    cycle();
    chk("t5 wen", {63'd0, rf_wen}, 64'd0);
    chk("t5 busy", {32'd0, busy}, 64'd0);
    rst = 1'b0;
    cycle();
    chk("t5 grant", {62'd0, last_ready}, 64'd1);

    // Randomized traffic with small index range to provoke hazards
    prev_rst = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (prev_rst) begin
        req_valid = 2'b00;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (!req_valid[i] || m_grant[i]) begin
            req_valid[i]         = 1'($urandom_range(0, 1));
            req_waddr[i*5 +: 5]  = 5'($urandom_range(0, 7));
            req_wdata[i*32 +: 32] = $urandom;
          end
        end
      end
      rst       = ($urandom_range(0, 49) == 0);
      prev_rst  = rst;
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd    = 5'($urandom_range(0, 7));
      chk_a     = 5'($urandom_range(0, 7));
      chk_b     = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
